// File: rtl/cen_mean_unit.sv
// Centering mean estimator for the FastICA whitening path.
// Accumulates a block of 2^LOG2_N multichannel samples, then presents the
// per-channel sums and means (floor or round-half-up) with a one-cycle done.
module cen_mean_unit #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2_N = 10,
  parameter int unsigned ROUND  = 0
) (
  input  logic                               clk,
  input  logic                               En,
  input  logic                               start,
  input  logic                               in_valid,
  input  logic [NCH*DATA_W-1:0]              x_in,
  output logic                               in_ready,
  output logic                               busy,
  output logic [LOG2_N:0]                    cnt,
  output logic [NCH*(DATA_W+LOG2_N)-1:0]     sum_out,
  output logic [NCH*DATA_W-1:0]              mean_out,
  output logic                               done
);

  localparam int unsigned ACC_W = DATA_W + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam int unsigned SUM_W = NCH * ACC_W;
  localparam int unsigned MW    = NCH * DATA_W;

  // Count value held just before the final sample of a block is accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);
  // Half an LSB of the mean, added before the shift when rounding is enabled.
  localparam logic signed [ACC_W:0] RND =
    (ROUND != 0) ? (ACC_W+1)'(1 << (LOG2_N - 1)) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q [NCH];
  logic signed [ACC_W-1:0]  acc_d [NCH];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic [MW-1:0]            mean_q, mean_d;
  logic                     done_q, done_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!En) begin
      state_q    <= S_IDLE;
      for (int c = 0; c < int'(NCH); c++) acc_q[c] <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      mean_q     <= '0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      mean_q     <= mean_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, accumulation and mean computation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    mean_d  = mean_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int c = 0; c < int'(NCH); c++) acc_d[c] = '0;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          for (int c = 0; c < int'(NCH); c++) begin
            acc_d[c] = acc_q[c] + $signed({{LOG2_N{x_in[c*DATA_W + DATA_W - 1]}},
                                            x_in[c*DATA_W +: DATA_W]});
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = S_DIV;
        end
      end
      S_DIV: begin
        for (int c = 0; c < int'(NCH); c++) begin
          sum_d[c*ACC_W +: ACC_W]   = acc_q[c];
          // One guard bit keeps the rounding add exact before the shift.
          mean_d[c*DATA_W +: DATA_W] =
            DATA_W'(($signed({acc_q[c][ACC_W-1], acc_q[c]}) + RND) >>> LOG2_N);
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          for (int c = 0; c < int'(NCH); c++) acc_d[c] = '0;
          cnt_d   = '0;
          state_d = S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_ACC);
    busy_d     = (state_d == S_ACC) || (state_d == S_DIV);
    done_d     = (state_d == S_DONE);
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign cnt      = cnt_q;
  assign sum_out  = sum_q;
  assign mean_out = mean_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cen_mean_unit.sv
// Bench for cen_mean_unit: directed block scenarios plus random traffic,
// two instances (floor and round-half-up) checked against a reference model.
module tb_cen_mean_unit;

  localparam int NCH    = 4;
  localparam int DATA_W = 16;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int ACC_W  = DATA_W + LOG2_N;

  logic clk;
  logic En;
  logic start;
  logic in_valid;
  logic [NCH*DATA_W-1:0] x_in;

  logic                   in_ready0, busy0, done0;
  logic [LOG2_N:0]        cnt0;
  logic [NCH*ACC_W-1:0]   sum0;
  logic [NCH*DATA_W-1:0]  mean0;
  logic                   in_ready1, busy1, done1;
  logic [LOG2_N:0]        cnt1;
  logic [NCH*ACC_W-1:0]   sum1;
  logic [NCH*DATA_W-1:0]  mean1;

  cen_mean_unit #(.NCH(NCH), .DATA_W(DATA_W), .LOG2_N(LOG2_N), .ROUND(0)) u_floor (
    .clk(clk), .En(En), .start(start), .in_valid(in_valid), .x_in(x_in),
    .in_ready(in_ready0), .busy(busy0), .cnt(cnt0), .sum_out(sum0),
    .mean_out(mean0), .done(done0));

  cen_mean_unit #(.NCH(NCH), .DATA_W(DATA_W), .LOG2_N(LOG2_N), .ROUND(1)) u_round (
    .clk(clk), .En(En), .start(start), .in_valid(in_valid), .x_in(x_in),
    .in_ready(in_ready1), .busy(busy1), .cnt(cnt1), .sum_out(sum1),
    .mean_out(mean1), .done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  logic en_s;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    en_s <= En;
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic signed [63:0] act,
                              input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endfunction

  // Expected block result: sums, floor means, rounded means, done cycle.
  typedef struct {
    logic [NCH-1:0][ACC_W-1:0]  s;
    logic [NCH-1:0][DATA_W-1:0] m0;
    logic [NCH-1:0][DATA_W-1:0] m1;
    int                         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  bit   mon_on = 0;

  // Mathematical floor division (SV '/' truncates toward zero).
  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference model of the block protocol, advanced once per clock edge.
  typedef enum int {P_IDLE, P_ACC, P_DIV, P_DONE} phase_e;
  phase_e ph = P_IDLE;
  int     m_cnt = 0;
  longint m_acc [NCH];

  task automatic model_edge(input logic en, input logic st, input logic v,
                            input logic [NCH*DATA_W-1:0] x);
    exp_t e;
    if (!en) begin
      if (ph == P_DIV) void'(exp_q.pop_back());
      ph = P_IDLE;
      m_cnt = 0;
      for (int c = 0; c < NCH; c++) m_acc[c] = 0;
    end else begin
      case (ph)
        P_IDLE, P_DONE: begin
          if (st) begin
            for (int c = 0; c < NCH; c++) m_acc[c] = 0;
            m_cnt = 0;
            ph = P_ACC;
          end else begin
            ph = P_IDLE;
          end
        end
        P_ACC: begin
          if (v) begin
            for (int c = 0; c < NCH; c++) begin
              logic [DATA_W-1:0] xv;
              xv = x[c*DATA_W +: DATA_W];
              m_acc[c] += longint'($signed(xv));
            end
            m_cnt++;
            if (m_cnt == N) begin
              for (int c = 0; c < NCH; c++) begin
                e.s[c]  = ACC_W'(m_acc[c]);
                e.m0[c] = DATA_W'(fdiv(m_acc[c], N));
                e.m1[c] = DATA_W'(fdiv(m_acc[c] + N / 2, N));
              end
              e.cyc = cyc + 1;
              exp_q.push_back(e);
              ph = P_DIV;
            end
          end
        end
        P_DIV: ph = P_DONE;
        default: ph = P_IDLE;
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model, check handshake outputs.
  task automatic step(input logic en, input logic st, input logic v,
                      input logic [NCH*DATA_W-1:0] x);
    En = en; start = st; in_valid = v; x_in = x;
    @(posedge clk);
    #1;
    model_edge(en, st, v, x);
    chk("in_ready", in_ready0, (ph == P_ACC) ? 1 : 0);
    chk("busy", busy0, (ph == P_ACC || ph == P_DIV) ? 1 : 0);
    chk("cnt", cnt0, m_cnt);
    chk("in_ready round", in_ready1, in_ready0);
    chk("busy round", busy1, busy0);
    chk("cnt round", cnt1, cnt0);
  endtask

  function automatic logic [NCH*DATA_W-1:0] mk(input int a, input int b,
                                               input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic signed [63:0] s_ch(input logic [NCH*ACC_W-1:0] v, input int c);
    logic [ACC_W-1:0] t;
    t = v[c*ACC_W +: ACC_W];
    return 64'($signed(t));
  endfunction

  function automatic logic signed [63:0] m_ch(input logic [NCH*DATA_W-1:0] v, input int c);
    logic [DATA_W-1:0] t;
    t = v[c*DATA_W +: DATA_W];
    return 64'($signed(t));
  endfunction

  // Monitor: pops an expectation on each done, else checks results are held.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!en_s) begin
        for (int c = 0; c < NCH; c++) begin
          held.s[c] = '0; held.m0[c] = '0; held.m1[c] = '0;
        end
        chk("done in reset", done0, 0);
      end else if (done0 === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected done", done0, 0);
        end else begin
          held = exp_q.pop_front();
          chk("done cycle", cyc, held.cyc);
        end
      end
      chk("done round", done1, done0);
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("sum ch%0d", c), s_ch(sum0, c), 64'($signed(held.s[c])));
        chk($sformatf("mean floor ch%0d", c), m_ch(mean0, c), 64'($signed(held.m0[c])));
        chk($sformatf("sum round ch%0d", c), s_ch(sum1, c), 64'($signed(held.s[c])));
        chk($sformatf("mean round ch%0d", c), m_ch(mean1, c), 64'($signed(held.m1[c])));
      end
    end
  end

  initial begin
    logic [NCH*DATA_W-1:0] z;
    int pat_v [7];
    int pat_x [7];
    z = '0;
    for (int c = 0; c < NCH; c++) m_acc[c] = 0;
    for (int c = 0; c < NCH; c++) begin
      held.s[c] = '0; held.m0[c] = '0; held.m1[c] = '0;
    end
    held.cyc = 0;

    // Reset state
    step(0, 0, 0, z);
    mon_on = 1;
    step(0, 1, 1, z);
    chk("reset done", done0, 0);
    chk("reset sum ch0", s_ch(sum0, 0), 0);
    chk("reset mean ch3", m_ch(mean0, 3), 0);

    // Ramp, negative ramp and full-scale channels in one block
    step(1, 1, 0, z);
    for (int i = 1; i <= 4; i++) step(1, 0, 1, mk(i, -i, 32767, -32768));
    step(1, 0, 0, z);
    chk("T1 done", done0, 1);
    chk("T1 sum ch0", s_ch(sum0, 0), 10);
    chk("T1 mean ch0", m_ch(mean0, 0), 2);
    chk("T2 sum ch1", s_ch(sum0, 1), -10);
    chk("T2 mean ch1", m_ch(mean0, 1), -3);
    chk("T2 round mean ch0", m_ch(mean1, 0), 3);
    chk("T2 round mean ch1", m_ch(mean1, 1), -2);
    chk("T3 sum ch2", s_ch(sum0, 2), 131068);
    chk("T3 mean ch2", m_ch(mean0, 2), 32767);
    chk("T3 sum ch3", s_ch(sum0, 3), -131072);
    chk("T3 mean ch3", m_ch(mean0, 3), -32768);
    step(1, 0, 0, z);
    chk("T1 done pulse width", done0, 0);
    chk("T1 cnt held", cnt0, 4);

    // Gapped valid pattern with a stray start mid-block
    pat_v = '{1, 0, 0, 1, 1, 0, 1};
    pat_x = '{7, 55, 66, -3, 100, 77, 9};
    step(1, 1, 0, z);
    for (int i = 0; i < 7; i++)
      step(1, (i == 2) ? 1'b1 : 1'b0, pat_v[i] != 0, mk(pat_x[i], 0, 0, 0));
    chk("T4 no early done", done0, 0);
    step(1, 0, 0, z);
    chk("T4 done", done0, 1);
    chk("T4 sum ch0", s_ch(sum0, 0), 113);
    chk("T4 mean ch0", m_ch(mean0, 0), 28);
    step(1, 0, 0, z);

    // Reset after two samples discards the block
    step(1, 1, 0, z);
    step(1, 0, 1, mk(3, 3, 3, 3));
    step(1, 0, 1, mk(3, 3, 3, 3));
    step(0, 0, 1, mk(3, 3, 3, 3));
    chk("T5 sum cleared", s_ch(sum0, 0), 0);
    chk("T5 mean cleared", m_ch(mean0, 0), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, mk(9, 9, 9, 9));
    step(1, 1, 0, z);
    for (int i = 0; i < 4; i++) step(1, 0, 1, mk(5, 5, 5, 5));
    step(1, 0, 0, z);
    chk("T5 done", done0, 1);
    chk("T5 sum ch1", s_ch(sum0, 1), 20);
    chk("T5 mean ch1", m_ch(mean0, 1), 5);
    step(1, 0, 0, z);

    // Back-to-back blocks with start held through DONE
    step(1, 1, 0, z);
    for (int i = 0; i < 4; i++) step(1, 1, 1, mk(8, -8, i, 0));
    step(1, 1, 0, z);
    chk("T6 done A", done0, 1);
    step(1, 1, 0, z);
    chk("T6 in_ready no idle", in_ready0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, mk(-1, 2, 1000, i));
    chk("T6 sum A held", s_ch(sum0, 0), 32);
    step(1, 0, 0, z);
    chk("T6 done B", done0, 1);
    chk("T6 sum B ch0", s_ch(sum0, 0), -4);
    step(1, 0, 0, z);

    // Random traffic: gaps, stray starts, full-range data, rare resets
    for (int i = 0; i < 3000; i++) begin
      logic [NCH*DATA_W-1:0] xr;
      xr = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) xr = mk(32767, -32768, 32767, -32768);
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), xr);
    end
    for (int i = 0; i < 6; i++) step(1, 0, 0, z);
    chk("pending results", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cen_mean_unit.md
Name: cen_mean_unit

Overview:
Parametrised successor to the whitening-stage adder. It is the centering mean estimator for the FastICA whitening path. On a start command it accumulates exactly N = 2^LOG2_N valid multichannel samples, then computes the per-channel mean (floor or round-half-up) and presents both sums and means with a one-cycle done pulse. The downstream centering/covariance logic consumes the means.

Parameters:
NCH, 4, number of channels
DATA_W, 16, signed sample width per channel
LOG2_N, 10, log2 of samples per block; legal range 1..16
ROUND, 0, 0 = mean is floor (arithmetic shift); 1 = add 2^(LOG2_N-1) before the shift
ACC_W, DATA_W+LOG2_N, accumulator width; derived, not overridable

Ports:
clk  in  1  rising-edge clock
En  in  1  synchronous active-low reset/clear
start  in  1  begin new block; sampled in IDLE and DONE only
in_valid  in  1  sample strobe
x_in  in  NCH*DATA_W  signed samples; channel c at bits [c*DATA_W +: DATA_W]
in_ready  out  1  high in ACC; a sample is accepted when in_valid && in_ready
busy  out  1  high in ACC and DIV
cnt  out  LOG2_N+1  samples accepted in current block
sum_out  out  NCH*ACC_W  signed final sums, same packing as x_in
mean_out  out  NCH*DATA_W  signed means
done  out  1  one-cycle pulse when sum_out/mean_out update

Behaviour:
- Reset: En low at a clk edge puts the FSM in IDLE and clears to 0 all accumulators, cnt, sum_out, mean_out, done, in_ready and busy. Reset takes priority over every other input, in any state.
- FSM states: IDLE, ACC, DIV, DONE.
- IDLE: start=1 clears the accumulators and cnt, then moves to ACC.
- ACC: each accepted sample adds sign-extended x_in[c] to acc[c] and increments cnt.
  - When the accepted sample makes cnt reach N, move to DIV.
  - in_valid=0 cycles are gaps: no change.
  - start is ignored in ACC.
- DIV (one cycle):
  - sum_out[c] <= acc[c].
  - mean_out[c] <= (acc[c] + (ROUND ? 2^(LOG2_N-1) : 0)) >>> LOG2_N, computed in ACC_W+1 bits and truncated to DATA_W.
  - The result always fits DATA_W; no saturation logic is needed.
  - Move to DONE.
- DONE (one cycle): done=1.
  - start=1 here behaves as in IDLE (clear, go to ACC); this allows back-to-back blocks.
  - Otherwise move to IDLE.
- Latency: done is high in the 2nd cycle after the edge that accepted the Nth sample.
- sum_out, mean_out and cnt hold their values until the next DIV (cnt until the next start) or until reset.
- Accumulation is exact: |sum| <= 2^(DATA_W-1)*N fits ACC_W signed; no wrap-around is possible.
- ROUND=1 with negative sums rounds half toward +inf, e.g. -2.5 -> -2.
- Reset mid-block discards the partial block. No done pulse is produced for it.

Test Plan:
1. NCH=4, DATA_W=16, LOG2_N=2, ROUND=0; start, then ch0 = 1,2,3,4 on consecutive cycles -> in_ready high for 4 cycles; sum_out[0]=10, mean_out[0]=2; done pulses exactly 2 cycles after the 4th acceptance; cnt=4.
2. Same block with ch1 = -1,-2,-3,-4 -> sum_out[1]=-10, mean_out[1]=-3 with ROUND=0; rerun with ROUND=1 -> ch0 mean 3, ch1 mean -2.
3. Full scale: ch2 = 32767 x4 and ch3 = -32768 x4 -> sum_out[2]=131068, mean_out[2]=32767; sum_out[3]=-131072, mean_out[3]=-32768; no wrap.
4. in_valid pattern 1,0,0,1,1,0,1 with a pulse on start mid-ACC -> exactly 4 samples accepted; the extra start is ignored; done follows the 7th cycle's acceptance with results equal to the 4 valid samples only.
5. En low for one cycle after 2 accepted samples -> next cycle: IDLE, all outputs 0, no done pulse. Then a fresh start with 4 samples of 5 -> mean_out=5, sum_out=20.
6. start held high through DONE -> a new block begins with no IDLE cycle and in_ready high on the next cycle; the previous results stay held until the second DIV.
